jk_sequencer: RTL and testbench
===============================

# jk_sequencer

Drive-side companion to the team's negedge-clocked JK flip-flop. It accepts a WIDTH-bit target pattern over a valid/ready handshake and emits one 2-bit jk code per clock, using the JK excitation table, so that an attached JK flip-flop's q follows the pattern LSB-first. It keeps an internal model of q and checks the flip-flop's fed-back q every cycle. Any divergence raises a sticky mismatch flag, so the block serves both as a stimulus engine and as a self-check for JK-based storage.

## Interface
- WIDTH, 8: pattern length in bits; legal values are 1 or more.
- clk  input  1  system clock; all block state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  a pattern is offered.
- start_ready  output  1  block is idle and can accept a pattern.
- pattern  input  WIDTH  target q sequence; bit 0 is applied first.
- use_toggle  input  1  sampled at accept: 1 selects toggle codes for transitions, 0 selects set/reset codes.
- jk  output  2  code to the flip-flop: jk[1]=J, jk[0]=K.
- q_fb  input  1  q fed back from the driven flip-flop.
- busy  output  1  high in INIT, RUN and DONE.
- done  output  1  one-cycle pulse while in DONE.
- mismatch  output  1  sticky check-failure flag.

## Operation
- States: IDLE, INIT, RUN, DONE.
- IDLE:
  - start_ready=1, jk=00.
  - Accept occurs when start_valid && start_ready at a posedge.
  - On accept: latch pattern and use_toggle, clear mismatch, set bit index to 0, go to INIT.
  - Changes to pattern or use_toggle after accept are ignored.
- INIT (1 cycle): jk=01 to force the flip-flop to 0, since it has no reset. Model q becomes 0; expected q = 0. Go to RUN.
- RUN (WIDTH cycles): target t = pattern[idx], model m.
  - m==t: jk=00.
  - m=0, t=1: jk=10, or 11 if use_toggle.
  - m=1, t=0: jk=01, or 11 if use_toggle.
  - At cycle end: m<=t, expected q <= t, idx++.
  - After idx reaches WIDTH-1, go to DONE.
- DONE (1 cycle): jk=00, done=1, busy=1. Go to IDLE.
- Check: at every posedge that ends an INIT or RUN cycle, if q_fb != expected q, set mismatch<=1.
  - mismatch is sticky and is cleared only by the next accept or by rst.
- start_valid while busy is ignored (start_ready=0). No pattern is queued.

## Timing
- Reset values: start_ready=1, jk=00, busy=0, done=0, mismatch=0; state=IDLE; idx=0; model q=0.
- Reset is asynchronous. Asserting rst mid-operation forces all of the above immediately, abandoning the pattern.
- jk changes only on posedge, so it is stable across the following negedge where the flip-flop samples. q_fb is valid at the next posedge.
- Cycle numbering, with the accept edge as edge 0:
  - INIT occupies cycle 1.
  - RUN bit k occupies cycle k+2.
  - DONE occupies cycle WIDTH+2; done and final mismatch are valid together in that cycle.
  - start_ready returns high in cycle WIDTH+3.
- Minimum accept-to-accept spacing is WIDTH+3 cycles. With start_valid held high, back-to-back patterns accept on edges 0, WIDTH+3, 2(WIDTH+3), ...
- WIDTH=1: RUN lasts one cycle; the sequence is INIT, RUN, DONE.
- Idx does not wrap; RUN exits exactly after bit WIDTH-1.

## Test plan
- Set/reset codes: reset, then accept pattern=8'b1011_0010 with use_toggle=0, bench JK flip-flop on negedge.
  - Required jk: 01, then 00,10,01,00,10,00,01,10.
  - done pulses in cycle 10; mismatch=0; flip-flop q sequence is 0,1,0,0,1,1,0,1.
- Toggle codes: same pattern with use_toggle=1.
  - Required jk: 01, then 00,11,11,00,11,00,11,11.
  - Same q sequence; mismatch=0.
- Unknown start state: pre-load the bench flip-flop to q=1, then run pattern=8'h00.
  - INIT drives q to 0; all RUN codes are 00; mismatch=0.
- Fault injection: hold q_fb stuck at 0 and run pattern=8'h01.
  - mismatch rises at the posedge ending cycle 2 and stays 1 through done.
  - The next accept clears it.
- Reset mid-run: assert rst during RUN bit 3.
  - Same cycle: jk=00, busy=0, start_ready=1, mismatch=0.
  - start_valid pulses during an earlier busy window produce no accept.
- Back-to-back: hold start_valid=1 with WIDTH=8.
  - Accepts occur on edges 0 and 11; each run produces one done pulse.

Source files
------------

// File: rtl/jk_sequencer_if.sv
// -----------------------------------------------------------------------------
// jk_sequencer_if
// Pattern-offer handshake between a pattern source and jk_sequencer.
//   start_valid  source -> sequencer  a pattern is offered
//   start_ready  sequencer -> source  sequencer is idle and will accept
//   pattern      source -> sequencer  WIDTH-bit target q sequence, bit 0 first
//   use_toggle   source -> sequencer  1: toggle codes for transitions, 0: set/reset codes
// -----------------------------------------------------------------------------
interface jk_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] pattern;
    logic             use_toggle;

    modport master (
        output start_valid,
        output pattern,
        output use_toggle,
        input  start_ready
    );

    modport slave (
        input  start_valid,
        input  pattern,
        input  use_toggle,
        output start_ready
    );
endinterface

// File: rtl/jk_sequencer.sv
// -----------------------------------------------------------------------------
// jk_sequencer
// Drives a negedge-clocked JK flip-flop so that its q follows a WIDTH-bit
// pattern LSB-first, using the JK excitation table. An internal model of q is
// compared against the fed-back q every INIT/RUN cycle; any divergence raises
// a sticky mismatch flag.
//
// Ports
//   clk         system clock, all state updates on posedge
//   rst         asynchronous active-high reset
//   start_if    slave side of the pattern-offer handshake
//   o_jk        code to the flip-flop, o_jk[1]=J, o_jk[0]=K (registered)
//   i_q_fb      q fed back from the driven flip-flop
//   o_busy      high in INIT, RUN and DONE
//   o_done      one-cycle pulse while in DONE
//   o_mismatch  sticky check-failure flag, cleared by accept or rst
// -----------------------------------------------------------------------------
module jk_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    jk_sequencer_if.slave      start_if,
    output logic [1:0]         o_jk,
    input  logic               i_q_fb,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_mismatch
);

    localparam int              IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pat;
    logic             r_tog;
    logic [IDX_W-1:0] r_idx;
    logic             r_model;
    logic             r_exp;
    logic             r_start_ready;
    logic [1:0]       r_jk;
    logic             r_busy;
    logic             r_done;
    logic             r_mismatch;

    logic             w_accept;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_t_nxt;
    logic             w_q_bad;

    // JK excitation: hold when already at target, else set/reset or toggle.
    function automatic logic [1:0] jk_code(input logic m, input logic t, input logic tog);
        if (m == t) begin
            return 2'b00;
        end
        if (tog) begin
            return 2'b11;
        end
        return t ? 2'b10 : 2'b01;
    endfunction

    assign w_accept  = (r_state == S_IDLE) && start_if.start_valid && r_start_ready;
    assign w_idx_nxt = r_idx + 1'b1;
    assign w_t_nxt   = r_pat[w_idx_nxt];
    assign w_q_bad   = (i_q_fb != r_exp);

    // Pattern and mode are captured only at accept; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pat <= start_if.pattern;
            r_tog <= start_if.use_toggle;
        end
    end

    // The code for a cycle is computed at the edge that starts it, so o_jk is
    // registered and stable across the negedge where the flip-flop samples.
    // r_model/r_exp hold the q the flip-flop must show at the end of the
    // current cycle; the check happens at the edge that ends INIT/RUN cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_model       <= 1'b0;
            r_exp         <= 1'b0;
            r_start_ready <= 1'b1;
            r_jk          <= 2'b00;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mismatch    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state       <= S_INIT;
                        r_jk          <= 2'b01;   // force q to 0; the flip-flop has no reset
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        r_mismatch    <= 1'b0;
                        r_idx         <= '0;
                        r_model       <= 1'b0;
                        r_exp         <= 1'b0;
                    end
                end
                S_INIT: begin
                    if (w_q_bad) begin
                        r_mismatch <= 1'b1;
                    end
                    r_state <= S_RUN;
                    r_jk    <= jk_code(r_model, r_pat[0], r_tog);
                    r_model <= r_pat[0];
                    r_exp   <= r_pat[0];
                end
                S_RUN: begin
                    if (w_q_bad) begin
                        r_mismatch <= 1'b1;
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_DONE;
                        r_jk    <= 2'b00;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx   <= w_idx_nxt;
                        r_jk    <= jk_code(r_model, w_t_nxt, r_tog);
                        r_model <= w_t_nxt;
                        r_exp   <= w_t_nxt;
                    end
                end
                S_DONE: begin
                    r_state       <= S_IDLE;
                    r_done        <= 1'b0;
                    r_busy        <= 1'b0;
                    r_start_ready <= 1'b1;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_jk          <= 2'b00;
                    r_done        <= 1'b0;
                    r_busy        <= 1'b0;
                    r_start_ready <= 1'b1;
                end
            endcase
        end
    end

    assign start_if.start_ready = r_start_ready;
    assign o_jk                 = r_jk;
    assign o_busy               = r_busy;
    assign o_done               = r_done;
    assign o_mismatch           = r_mismatch;

endmodule

// File: tb/tb_jk_sequencer.sv
module tb_jk_sequencer;

    localparam int WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] jk;
    logic       q_fb;
    logic       busy;
    logic       done;
    logic       mismatch;

    logic       ff_q    = 1'b0;
    logic       preload = 1'b0;
    logic       stuck   = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected jk per cycle 1..10 for pattern 8'b1011_0010.
    logic [1:0] EXP_SR [10] = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    logic [1:0] EXP_TG [10] = '{2'b01, 2'b00, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00};

    always #5 clk = ~clk;

    jk_sequencer_if #(.WIDTH(WIDTH)) start_if ();

    jk_sequencer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_if   (start_if.slave),
        .o_jk       (jk),
        .i_q_fb     (q_fb),
        .o_busy     (busy),
        .o_done     (done),
        .o_mismatch (mismatch)
    );

    // Negedge-clocked JK flip-flop model with a preload hook.
    always @(negedge clk) begin
        if (preload) begin
            ff_q <= 1'b1;
        end else begin
            case (jk)
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end

    assign q_fb = stuck ? 1'b0 : ff_q;

    // Offer a pattern, let the next posedge accept it, then scramble the inputs.
    task automatic offer(input logic [WIDTH-1:0] pat, input logic tog);
        start_if.pattern     = pat;
        start_if.use_toggle  = tog;
        start_if.start_valid = 1'b1;
        @(posedge clk); #1;
        start_if.start_valid = 1'b0;
        start_if.pattern     = ~pat;
        start_if.use_toggle  = ~tog;
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk); #1;
        n_checks++; if (start_if.start_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", start_if.start_ready); else n_pass++;
        n_checks++; if (jk !== 2'b00) $display("FAIL rst_jk got %b want 00", jk); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
        n_checks++; if (mismatch !== 1'b0) $display("FAIL rst_mismatch got %b want 0", mismatch); else n_pass++;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (start_if.start_ready !== 1'b1) $display("FAIL idle_ready got %b want 1", start_if.start_ready); else n_pass++;
    endtask

    task automatic test_set_reset();
        logic [WIDTH-1:0] pat;
        pat = 8'b1011_0010;
        offer(pat, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            n_checks++; if (jk !== EXP_SR[c-1]) $display("FAIL sr_jk cycle %0d got %b want %b", c, jk, EXP_SR[c-1]); else n_pass++;
            n_checks++; if (done !== (c == 10)) $display("FAIL sr_done cycle %0d got %b want %b", c, done, (c == 10)); else n_pass++;
            if (c >= 3) begin
                n_checks++; if (ff_q !== pat[c-3]) $display("FAIL sr_q cycle %0d got %b want %b", c, ff_q, pat[c-3]); else n_pass++;
            end
            if (c == 10) begin
                n_checks++; if (mismatch !== 1'b0) $display("FAIL sr_mismatch got %b want 0", mismatch); else n_pass++;
            end
            @(posedge clk); #1;
        end
        n_checks++; if (start_if.start_ready !== 1'b1) $display("FAIL sr_ready_back got %b want 1", start_if.start_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL sr_busy_end got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_toggle();
        logic [WIDTH-1:0] pat;
        pat = 8'b1011_0010;
        offer(pat, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            n_checks++; if (jk !== EXP_TG[c-1]) $display("FAIL tg_jk cycle %0d got %b want %b", c, jk, EXP_TG[c-1]); else n_pass++;
            n_checks++; if (done !== (c == 10)) $display("FAIL tg_done cycle %0d got %b want %b", c, done, (c == 10)); else n_pass++;
            if (c >= 3) begin
                n_checks++; if (ff_q !== pat[c-3]) $display("FAIL tg_q cycle %0d got %b want %b", c, ff_q, pat[c-3]); else n_pass++;
            end
            if (c == 10) begin
                n_checks++; if (mismatch !== 1'b0) $display("FAIL tg_mismatch got %b want 0", mismatch); else n_pass++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_unknown_start();
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
        offer(8'h00, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            n_checks++; if (jk !== ((c == 1) ? 2'b01 : 2'b00)) $display("FAIL unk_jk cycle %0d got %b want %b", c, jk, ((c == 1) ? 2'b01 : 2'b00)); else n_pass++;
            if (c >= 2) begin
                n_checks++; if (ff_q !== 1'b0) $display("FAIL unk_q cycle %0d got %b want 0", c, ff_q); else n_pass++;
            end
            if (c == 10) begin
                n_checks++; if (done !== 1'b1) $display("FAIL unk_done got %b want 1", done); else n_pass++;
                n_checks++; if (mismatch !== 1'b0) $display("FAIL unk_mismatch got %b want 0", mismatch); else n_pass++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fault();
        stuck = 1'b1;
        offer(8'h01, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            if (c <= 2) begin
                n_checks++; if (mismatch !== 1'b0) $display("FAIL flt_early cycle %0d got %b want 0", c, mismatch); else n_pass++;
            end else begin
                n_checks++; if (mismatch !== 1'b1) $display("FAIL flt_sticky cycle %0d got %b want 1", c, mismatch); else n_pass++;
            end
            if (c == 10) begin
                n_checks++; if (done !== 1'b1) $display("FAIL flt_done got %b want 1", done); else n_pass++;
            end
            @(posedge clk); #1;
        end
        stuck = 1'b0;
        offer(8'h00, 1'b0);
        n_checks++; if (mismatch !== 1'b0) $display("FAIL flt_clear got %b want 0", mismatch); else n_pass++;
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) begin
                n_checks++; if (mismatch !== 1'b0) $display("FAIL flt_rerun got %b want 0", mismatch); else n_pass++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        stuck = 1'b1;
        offer(8'b0000_1001, 1'b0);
        @(posedge clk); #1;                       // cycle 2
        start_if.pattern     = 8'hFF;
        start_if.use_toggle  = 1'b1;
        start_if.start_valid = 1'b1;
        @(posedge clk); #1;                       // cycle 3
        start_if.start_valid = 1'b0;
        n_checks++; if (start_if.start_ready !== 1'b0) $display("FAIL mid_ready_busy got %b want 0", start_if.start_ready); else n_pass++;
        n_checks++; if (mismatch !== 1'b1) $display("FAIL mid_mismatch_set got %b want 1", mismatch); else n_pass++;
        @(posedge clk); #1;                       // cycle 4
        n_checks++; if (jk !== 2'b00) $display("FAIL mid_no_accept_jk got %b want 00", jk); else n_pass++;
        @(posedge clk); #1;                       // cycle 5, RUN bit 3
        n_checks++; if (jk !== 2'b10) $display("FAIL mid_bit3_jk got %b want 10", jk); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (jk !== 2'b00) $display("FAIL mid_rst_jk got %b want 00", jk); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (start_if.start_ready !== 1'b1) $display("FAIL mid_rst_ready got %b want 1", start_if.start_ready); else n_pass++;
        n_checks++; if (mismatch !== 1'b0) $display("FAIL mid_rst_mismatch got %b want 0", mismatch); else n_pass++;
        stuck = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_after_busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n_done;
        n_done = 0;
        start_if.pattern     = 8'h5A;
        start_if.use_toggle  = 1'b0;
        start_if.start_valid = 1'b1;
        @(posedge clk); #1;                       // edge 0 accepted, cycle 1
        for (int c = 1; c <= 21; c++) begin
            if (done === 1'b1) n_done++;
            n_checks++; if (done !== (c == 10 || c == 21)) $display("FAIL b2b_done cycle %0d got %b want %b", c, done, (c == 10 || c == 21)); else n_pass++;
            if (c == 5) begin
                n_checks++; if (start_if.start_ready !== 1'b0) $display("FAIL b2b_ready_busy got %b want 0", start_if.start_ready); else n_pass++;
            end
            if (c == 11) begin
                n_checks++; if (start_if.start_ready !== 1'b1) $display("FAIL b2b_ready_gap got %b want 1", start_if.start_ready); else n_pass++;
            end
            if (c == 12) begin
                n_checks++; if (jk !== 2'b01) $display("FAIL b2b_init2 got %b want 01", jk); else n_pass++;
            end
            if (c == 21) begin
                n_checks++; if (mismatch !== 1'b0) $display("FAIL b2b_mismatch got %b want 0", mismatch); else n_pass++;
            end
            @(posedge clk); #1;
        end
        start_if.start_valid = 1'b0;              // cycle 22: stop before a third accept
        n_checks++; if (n_done !== 2) $display("FAIL b2b_done_count got %0d want 2", n_done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL b2b_busy_end got %b want 0", busy); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL b2b_no_third got %b want 0", busy); else n_pass++;
    endtask

    initial begin
        start_if.start_valid = 1'b0;
        start_if.pattern     = '0;
        start_if.use_toggle  = 1'b0;
        test_reset();
        test_set_reset();
        test_toggle();
        test_unknown_start();
        test_fault();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", n_checks);
        $fatal(1, "timeout");
    end

endmodule
